// File: rtl/round_judge.sv
// Two-player round referee: detects crashes, waits a settle window for a near-simultaneous
// second crash, then reports win/draw and keeps match tallies. Optional macro: ROUND_TIMEOUT_EN.
module round_judge #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned WIN_TARGET     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       crash_p1,
  input  logic       crash_p2,
  input  logic       new_match,
  output logic       p1_win,
  output logic       p2_win,
  output logic       win_strobe,
  output logic       draw,
  output logic       round_active,
  output logic       match_over,
  output logic [3:0] p1_tally,
  output logic [3:0] p2_tally
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_SETTLE,
    S_RESULT,
    S_STROBE,
    S_OVER
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] TARGET      = 4'(WIN_TARGET);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("round_judge: SETTLE_CYCLES must be 1..15");
  end
  if (WIN_TARGET < 1 || WIN_TARGET > 15) begin : g_bad_target
    $error("round_judge: WIN_TARGET must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("round_judge: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t     state, state_d;
  logic [3:0] settle_cnt, settle_cnt_d;
  logic       hit_p1, hit_p1_d;
  logic       hit_p2, hit_p2_d;
  logic       p1_win_d, p2_win_d;
  logic       win_strobe_d, draw_d;
  logic [3:0] p1_tally_d, p2_tally_d;
`ifdef ROUND_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] round_timer, round_timer_d;
`endif

  // NOTE: every next-state variable gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    hit_p1_d     = hit_p1;
    hit_p2_d     = hit_p2;
    p1_win_d     = p1_win;
    p2_win_d     = p2_win;
    win_strobe_d = 1'b0;
    draw_d       = 1'b0;
    p1_tally_d   = p1_tally;
    p2_tally_d   = p2_tally;
`ifdef ROUND_TIMEOUT_EN
    round_timer_d = round_timer;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PLAY;
          p1_win_d = 1'b0;
          p2_win_d = 1'b0;
`ifdef ROUND_TIMEOUT_EN
          round_timer_d = '0;
`endif
        end
      end

      S_PLAY: begin
        if (crash_p1 || crash_p2) begin
          hit_p1_d     = crash_p1;
          hit_p2_d     = crash_p2;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = S_SETTLE;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (round_timer == TIMER_LAST) begin
          draw_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          round_timer_d = round_timer + 16'd1;
        end
`endif
      end

      S_SETTLE: begin
        hit_p1_d     = hit_p1 | crash_p1;
        hit_p2_d     = hit_p2 | crash_p2;
        settle_cnt_d = settle_cnt - 4'd1;
        // The decrement that lands on zero is the last settle cycle.
        if (settle_cnt <= 4'd1) begin
          state_d = S_RESULT;
        end
      end

      S_RESULT: begin
        if (hit_p1 && hit_p2) begin
          draw_d  = 1'b1;
          state_d = S_IDLE;
        end else if (hit_p2) begin
          p1_win_d = 1'b1;
          state_d  = S_STROBE;
        end else if (hit_p1) begin
          p2_win_d = 1'b1;
          state_d  = S_STROBE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_STROBE: begin
        win_strobe_d = 1'b1;
        state_d      = S_IDLE;
        if (p1_win) begin
          if (p1_tally < TARGET) p1_tally_d = p1_tally + 4'd1;
          if (p1_tally + 4'd1 >= TARGET) state_d = S_OVER;
        end else if (p2_win) begin
          if (p2_tally < TARGET) p2_tally_d = p2_tally + 4'd1;
          if (p2_tally + 4'd1 >= TARGET) state_d = S_OVER;
        end
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Match restart overrides whatever the state logic decided above.
    if (new_match) begin
      state_d      = S_IDLE;
      p1_tally_d   = '0;
      p2_tally_d   = '0;
      p1_win_d     = 1'b0;
      p2_win_d     = 1'b0;
      win_strobe_d = 1'b0;
      draw_d       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      hit_p1     <= 1'b0;
      hit_p2     <= 1'b0;
      p1_win     <= 1'b0;
      p2_win     <= 1'b0;
      win_strobe <= 1'b0;
      draw       <= 1'b0;
      p1_tally   <= '0;
      p2_tally   <= '0;
`ifdef ROUND_TIMEOUT_EN
      round_timer <= '0;
`endif
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      hit_p1     <= hit_p1_d;
      hit_p2     <= hit_p2_d;
      p1_win     <= p1_win_d;
      p2_win     <= p2_win_d;
      win_strobe <= win_strobe_d;
      draw       <= draw_d;
      p1_tally   <= p1_tally_d;
      p2_tally   <= p2_tally_d;
`ifdef ROUND_TIMEOUT_EN
      round_timer <= round_timer_d;
`endif
    end
  end

  assign round_active = (state == S_PLAY) || (state == S_SETTLE);
  assign match_over   = (state == S_OVER);

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge with SETTLE_CYCLES=4, WIN_TARGET=3, TIMEOUT_CYCLES=100.
// Cycle tables plus hand-written sequences for match end, restart, async reset and timeout.
module tb_round_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       crash_p1 = 1'b0;
  logic       crash_p2 = 1'b0;
  logic       new_match = 1'b0;
  logic       p1_win, p2_win, win_strobe, draw, round_active, match_over;
  logic [3:0] p1_tally, p2_tally;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  round_judge #(
    .SETTLE_CYCLES (4),
    .WIN_TARGET    (3),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .crash_p1    (crash_p1),
    .crash_p2    (crash_p2),
    .new_match   (new_match),
    .p1_win      (p1_win),
    .p2_win      (p2_win),
    .win_strobe  (win_strobe),
    .draw        (draw),
    .round_active(round_active),
    .match_over  (match_over),
    .p1_tally    (p1_tally),
    .p2_tally    (p2_tally)
  );

  // {p1_win, p2_win, win_strobe, draw, round_active, match_over, p1_tally, p2_tally}
  logic [13:0] obs;
  assign obs = {p1_win, p2_win, win_strobe, draw, round_active, match_over, p1_tally, p2_tally};

  typedef struct {
    string       name;
    logic        start;
    logic        c1;
    logic        c2;
    logic        nm;
    logic [13:0] exp;
  } vec_t;

  function automatic logic [13:0] ex(input bit w1, input bit w2, input bit st, input bit dr,
                                     input bit act, input bit ov, input int t1, input int t2);
    return {w1, w2, st, dr, act, ov, 4'(t1), 4'(t2)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full round where one player crashes alone; checks flag timing, strobe latency and tallies.
  task automatic win_round(input bit p2_crashes, input int t1, input int t2, input bit ov);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    if (p2_crashes) crash_p2 = 1'b1;
    else            crash_p1 = 1'b1;
    tick();                      // edge t
    crash_p1 = 1'b0;
    crash_p2 = 1'b0;
    repeat (4) tick();           // edge t+4, RESULT
    tick();                      // edge t+5
    check("win_flag", {30'd0, p1_win, p2_win}, p2_crashes ? 32'd2 : 32'd1);
    check("strobe_not_early", {31'd0, win_strobe}, 32'd0);
    tick();                      // edge t+6
    check("strobe", {31'd0, win_strobe}, 32'd1);
    check("tally", {24'd0, p1_tally, p2_tally}, {24'd0, 4'(t1), 4'(t2)});
    check("match_over", {31'd0, match_over}, {31'd0, ov});
    tick();
    check("strobe_one_cycle", {31'd0, win_strobe}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    // IDLE ignores crashes; new_match beats start.
    vecs.push_back('{"idle_crash_ignored", 0, 1, 1, 0, ex(0,0,0,0,0,0,0,0)});
    vecs.push_back('{"new_match_beats_start", 1, 0, 0, 1, ex(0,0,0,0,0,0,0,0)});
    // Round 1: player 2 crashes alone -> player 1 wins.
    vecs.push_back('{"start",        1, 0, 0, 0, ex(0,0,0,0,1,0,0,0)});
    vecs.push_back('{"play",         0, 0, 0, 0, ex(0,0,0,0,1,0,0,0)});
    vecs.push_back('{"crash_p2",     0, 0, 1, 0, ex(0,0,0,0,1,0,0,0)});
    vecs.push_back('{"settle_1",     0, 0, 0, 0, ex(0,0,0,0,1,0,0,0)});
    vecs.push_back('{"settle_2",     0, 0, 0, 0, ex(0,0,0,0,1,0,0,0)});
    vecs.push_back('{"settle_3",     0, 0, 0, 0, ex(0,0,0,0,1,0,0,0)});
    vecs.push_back('{"to_result",    0, 0, 0, 0, ex(0,0,0,0,0,0,0,0)});
    vecs.push_back('{"p1_win_set",   0, 0, 0, 0, ex(1,0,0,0,0,0,0,0)});
    vecs.push_back('{"strobe_tally", 0, 0, 0, 0, ex(1,0,1,0,0,0,1,0)});
    vecs.push_back('{"win_held",     0, 0, 0, 0, ex(1,0,0,0,0,0,1,0)});
    // Round 2: p1 crashes, p2 crashes two cycles later -> draw.
    vecs.push_back('{"start2_clears_win", 1, 0, 0, 0, ex(0,0,0,0,1,0,1,0)});
    vecs.push_back('{"crash_p1",     0, 1, 0, 0, ex(0,0,0,0,1,0,1,0)});
    vecs.push_back('{"settle_a",     0, 0, 0, 0, ex(0,0,0,0,1,0,1,0)});
    vecs.push_back('{"late_crash_p2",0, 0, 1, 0, ex(0,0,0,0,1,0,1,0)});
    vecs.push_back('{"settle_b",     0, 0, 0, 0, ex(0,0,0,0,1,0,1,0)});
    vecs.push_back('{"to_result2",   0, 0, 0, 0, ex(0,0,0,0,0,0,1,0)});
    vecs.push_back('{"draw_pulse",   0, 0, 0, 0, ex(0,0,0,1,0,0,1,0)});
    vecs.push_back('{"draw_one_cycle",0, 0, 0, 0, ex(0,0,0,0,0,0,1,0)});

    #2 reset = 1'b1;
    #1 check("reset_outputs", {18'd0, obs}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    foreach (vecs[i]) begin
      start     = vecs[i].start;
      crash_p1  = vecs[i].c1;
      crash_p2  = vecs[i].c2;
      new_match = vecs[i].nm;
      tick();
      check(vecs[i].name, {18'd0, obs}, {18'd0, vecs[i].exp});
    end
    start = 1'b0; crash_p1 = 1'b0; crash_p2 = 1'b0; new_match = 1'b0;

    // Two more player-1 wins end the match at the target.
    win_round(1'b1, 2, 0, 1'b0);
    win_round(1'b1, 3, 0, 1'b1);

    start = 1'b1;
    crash_p1 = 1'b1;
    repeat (3) tick();
    check("over_holds", {18'd0, obs}, {18'd0, ex(1,0,0,0,0,1,3,0)});
    start = 1'b0;
    crash_p1 = 1'b0;
    new_match = 1'b1;
    tick();
    check("new_match_clears", {18'd0, obs}, 32'd0);
    new_match = 1'b0;

    // Player 2 wins once, then a round is cut short by reset during SETTLE.
    win_round(1'b0, 0, 1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    crash_p1 = 1'b1;
    tick();
    crash_p1 = 1'b0;
    tick();
    tick();
    #3 reset = 1'b1;
    #1 check("async_reset_mid_settle", {18'd0, obs}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    begin
      int seen = 0;
      repeat (12) begin
        tick();
        if (win_strobe || draw || round_active) seen++;
      end
      check("no_pulse_after_reset", seen, 0);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    begin
      int cyc = 0;
      bit got = 1'b0;
      for (int i = 1; i <= 300 && !got; i++) begin
        tick();
        if (draw) begin
          got = 1'b1;
          cyc = i;
        end
      end
      check("timeout_draw_cycles", cyc, 100);
      check("timeout_back_to_idle", {31'd0, round_active}, 32'd0);
    end
`else
    repeat (200) tick();
    check("no_timeout_still_active", {31'd0, round_active}, 32'd1);
    new_match = 1'b1;
    tick();
    new_match = 1'b0;
    check("new_match_ends_play", {31'd0, round_active}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
